maxpool_2x2: RTL and testbench
==============================

Name: maxpool_2x2

Overview:
- 2x2, stride-2 signed max-pooling stage placed directly downstream of LineBuffer_2.
- Consumes LineBuffer_2's column stream: a vertically aligned pixel pair (current row, previous row) on every valid beat.
- Emits one pooled value per non-overlapping 2x2 window of the feature map.
- No backpressure: the block accepts every in_valid beat.

Parameters:
- DATA_W, 32, pixel width; signed two's complement.
- IMG_W, 28, input feature-map width in columns (beats per line-pair row); must be >= 2.
- IMG_H, 28, input feature-map height; line buffer produces IMG_H-1 beat-rows per frame; must be >= 2.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- d_in1  in  DATA_W  current-row pixel (LineBuffer_2 d_out1)
- d_in2  in  DATA_W  previous-row pixel, same column (LineBuffer_2 d_out2)
- in_valid  in  1  beat qualifier (LineBuffer_2 out_valid)
- d_out  out  DATA_W  pooled maximum
- out_valid  out  1  d_out qualifier, one-cycle pulse per window
- frame_done  out  1  one-cycle pulse after the last beat of a frame

Behaviour:
- Reset (async, rst_n=0):
  - d_out=0, out_valid=0, frame_done=0.
  - col_cnt=0, row_cnt=0, hold register=0.
  - Asserting reset mid-frame discards the partial window; the next accepted beat is treated as row_cnt=0, col_cnt=0.
- Counters advance only on in_valid=1. Idle cycles are legal anywhere and change no state.
  - col_cnt: 0..IMG_W-1, wraps to 0.
  - row_cnt: 0..IMG_H-2, increments on the col_cnt wrap.
- Active rows: row_cnt even pairs image rows (row_cnt, row_cnt+1). Beats with row_cnt odd are consumed and counted but produce no output.
- Vertical max: vmax = signed max(d_in1, d_in2). On a tie either value is correct; the values are equal.
- Active row, col_cnt even: hold <= vmax; no output.
- Active row, col_cnt odd: next cycle d_out = signed max(hold, vmax) and out_valid=1. Latency is 1 clock from the second-column beat.
- Odd IMG_W: the last column (col_cnt=IMG_W-1, even) is loaded into hold but never emitted; hold is overwritten by the next window.
- Odd IMG_H: the last image row is never paired and is dropped. Outputs per frame = floor(IMG_W/2) * floor(IMG_H/2).
- frame_done:
  - Pulses one cycle after the beat with row_cnt=IMG_H-2 and col_cnt=IMG_W-1.
  - Both counters return to 0 at that beat.
  - If that beat also completes a window, frame_done coincides with that out_valid.
- Back-to-back frames need no gap cycle.
- d_out holds its last value when out_valid=0.
- Comparisons are full-width signed. No saturation or truncation; output width equals input width.

Test Plan:
- Reset: rst_n=0 with random inputs toggling -> d_out=0, out_valid=0, frame_done=0 throughout.
- Basic window (IMG_W=4, IMG_H=4): 12 contiguous beats, d_in1=10*row_cnt+col, d_in2=d_in1-100.
  - Expect out_valid pulses after beats (0,1), (0,3), (2,1), (2,3) with d_out=1, 3, 21, 23.
  - Beats with row_cnt=1 produce nothing.
  - frame_done pulses with the 4th output.
- Signed compare: window pairs (-5,-7) and (-3,-9).
  - Expect d_out = -3 (0xFFFFFFFD).
  - With values (0x80000000, 0x7FFFFFFF) in the window, expect 0x7FFFFFFF.
- Gapped input: repeat the basic-window case with in_valid toggling every cycle, as LineBuffer_2 emits.
  - Expect the identical output sequence, each out_valid one cycle after its odd-column beat.
- Odd geometry (IMG_W=5, IMG_H=5):
  - Exactly 4 outputs per frame.
  - Column 4 and image row 4 never influence d_out; drive them to 0x7FFFFFFF and check.
- Mid-frame reset: pulse rst_n low after 6 beats, then restart a full frame.
  - Expect only the new frame's 4 correct outputs, with no stale hold value.

Source files
------------

// File: rtl/maxpool_2x2.sv
// -----------------------------------------------------------------------------
// maxpool_2x2
//   2x2, stride-2 signed max-pooling stage fed by a line buffer column stream.
//   Each valid beat carries a vertically aligned pixel pair. On even beat-rows
//   the pair max of an even column is held; the following odd column closes the
//   window and the pooled value is emitted one clock later. Odd beat-rows, a
//   trailing odd column and a trailing odd image row are consumed silently.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   d_in1      in   current-row pixel (signed, DATA_W)
//   d_in2      in   previous-row pixel, same column (signed, DATA_W)
//   in_valid   in   beat qualifier; every beat is accepted
//   d_out      out  pooled maximum, held while out_valid is low
//   out_valid  out  one-cycle pulse per completed 2x2 window
//   frame_done out  one-cycle pulse after the last beat of a frame
// -----------------------------------------------------------------------------
module maxpool_2x2 #(
   parameter int DATA_W = 32,
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] d_in1,
   input  logic [DATA_W-1:0] d_in2,
   input  logic              in_valid,
   output logic [DATA_W-1:0] d_out,
   output logic              out_valid,
   output logic              frame_done
);

   // Column counter spans 0..IMG_W-1, row counter spans 0..IMG_H-2.
   localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 2);

   logic [COL_W-1:0] col_q, col_d;
   logic [ROW_W-1:0] row_q, row_d;

   logic signed [DATA_W-1:0] pix_cur;
   logic signed [DATA_W-1:0] pix_prev;
   logic signed [DATA_W-1:0] vmax;
   logic signed [DATA_W-1:0] wmax;
   logic signed [DATA_W-1:0] hold_q, hold_d;
   logic signed [DATA_W-1:0] dout_q, dout_d;

   logic out_valid_q, out_valid_d;
   logic frame_done_q, frame_done_d;

   logic col_last;
   logic row_last;
   logic row_active;

   // Treat both inputs as two's complement so the compares are signed.
   assign pix_cur  = $signed(d_in1);
   assign pix_prev = $signed(d_in2);

   assign vmax = (pix_cur > pix_prev) ? pix_cur : pix_prev;
   assign wmax = (hold_q > vmax) ? hold_q : vmax;

   assign col_last   = (col_q == COL_LAST);
   assign row_last   = (row_q == ROW_LAST);
   // Even beat-rows pair image rows (row, row+1); odd beat-rows straddle two
   // windows and are skipped.
   assign row_active = ~row_q[0];

   // NOTE: every signal driven here gets a default first, so no path leaves a
   // value unassigned and no latch is inferred.
   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      hold_d       = hold_q;
      dout_d       = dout_q;
      out_valid_d  = 1'b0;
      frame_done_d = 1'b0;

      if (in_valid) begin
         if (col_last) begin
            col_d = '0;
            row_d = row_last ? '0 : row_q + ROW_W'(1);
         end else begin
            col_d = col_q + COL_W'(1);
         end

         if (row_active) begin
            if (!col_q[0]) begin
               // Left half of a window; a trailing odd column lands here too
               // and is simply overwritten by the next window.
               hold_d = vmax;
            end else begin
               dout_d      = wmax;
               out_valid_d = 1'b1;
            end
         end

         frame_done_d = col_last & row_last;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of the others, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q        <= '0;
         row_q        <= '0;
         hold_q       <= '0;
         dout_q       <= '0;
         out_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         hold_q       <= hold_d;
         dout_q       <= dout_d;
         out_valid_q  <= out_valid_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign d_out      = dout_q;
   assign out_valid  = out_valid_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_maxpool_2x2.sv
// -----------------------------------------------------------------------------
// tb_maxpool_2x2
//   Self-checking bench for maxpool_2x2. Instance A runs a 4x4 geometry and
//   instance B a 5x5 geometry. The stimulus task walks beat rows and columns,
//   computes each window maximum from the four pixels it drove, and queues the
//   expected event (value, frame_done, arrival cycle). A monitor on the falling
//   edge pops and compares every out_valid / frame_done event.
// -----------------------------------------------------------------------------
module tb_maxpool_2x2;

   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   logic signed [DW-1:0] a_d1, a_d2, b_d1, b_d2;
   logic                 a_v, b_v;
   logic [DW-1:0]        a_out, b_out;
   logic                 a_ov, a_fd, b_ov, b_fd;

   maxpool_2x2 #(.DATA_W(DW), .IMG_W(4), .IMG_H(4)) u_dut_a (
      .clk        (clk),
      .rst_n      (rst_n),
      .d_in1      (a_d1),
      .d_in2      (a_d2),
      .in_valid   (a_v),
      .d_out      (a_out),
      .out_valid  (a_ov),
      .frame_done (a_fd)
   );

   maxpool_2x2 #(.DATA_W(DW), .IMG_W(5), .IMG_H(5)) u_dut_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .d_in1      (b_d1),
      .d_in2      (b_d2),
      .in_valid   (b_v),
      .d_out      (b_out),
      .out_valid  (b_ov),
      .frame_done (b_fd)
   );

   typedef struct {
      int            cyc;
      logic          has_out;
      logic [DW-1:0] val;
      logic          fd;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];

   int cyc      = 0;
   int checks   = 0;
   int failures = 0;
   int b_cnt    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [DW-1:0] got,
                        input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)",
                  tag, got, exp, cyc);
      end
   endtask

   // Compare one observed output event against the head of the queue.
   task automatic mon(input bit sel, input logic ov, input logic fd,
                      input logic [DW-1:0] dout);
      exp_t  e;
      string pre;
      pre = sel ? "b_" : "a_";
      if (ov === 1'b1 || fd === 1'b1) begin
         if (sel && ov === 1'b1) b_cnt++;
         if ((sel ? q_b.size() : q_a.size()) == 0) begin
            check({pre, "spurious"}, {30'b0, ov, fd}, '0);
         end else begin
            e = sel ? q_b.pop_front() : q_a.pop_front();
            check({pre, "latency"}, cyc, e.cyc);
            check({pre, "out_valid"}, {31'b0, ov}, {31'b0, e.has_out});
            check({pre, "frame_done"}, {31'b0, fd}, {31'b0, e.fd});
            if (e.has_out) check({pre, "d_out"}, dout, e.val);
         end
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         mon(1'b0, a_ov, a_fd, a_out);
         mon(1'b1, b_ov, b_fd, b_out);
      end
   end

   task automatic drive(input bit sel, input logic v,
                        input logic signed [DW-1:0] d1,
                        input logic signed [DW-1:0] d2);
      if (sel) begin
         b_v = v; b_d1 = d1; b_d2 = d2;
      end else begin
         a_v = v; a_d1 = d1; a_d2 = d2;
      end
   endtask

   // Pixel pair for beat (r, c). Mode 0: ramp, 1: signed corner cases,
   // 2: odd geometry with the dropped column / row driven to the max positive.
   task automatic pixel(input int mode, input int r, input int c,
                        input int w, input int h,
                        output logic signed [DW-1:0] d1,
                        output logic signed [DW-1:0] d2);
      int t1, t2;
      t1 = int'($urandom_range(2000)) - 1000;
      t2 = int'($urandom_range(2000)) - 1000;
      d1 = t1;
      d2 = t2;
      case (mode)
         0: begin
            d1 = 10 * r + c;
            d2 = 10 * r + c - 100;
         end
         1: begin
            if (r == 0) begin
               case (c)
                  0: begin d1 = -5;            d2 = -7;            end
                  1: begin d1 = -3;            d2 = -9;            end
                  2: begin d1 = 32'h8000_0000; d2 = 32'h8000_0000; end
                  default: begin d1 = 32'h7FFF_FFFF; d2 = 32'h8000_0000; end
               endcase
            end else begin
               d1 = $urandom();
               d2 = $urandom();
            end
         end
         default: begin
            if (c == w - 1) begin
               d1 = 32'h7FFF_FFFF;
               d2 = 32'h7FFF_FFFF;
            end else if (r == h - 2) begin
               d1 = 32'h7FFF_FFFF;
            end
         end
      endcase
   endtask

   function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] x,
                                                 input logic signed [DW-1:0] y);
      return (x > y) ? x : y;
   endfunction

   // Drive one frame (optionally gapped, optionally stopped after stop_after
   // beats) and queue the expected window maxima and frame_done.
   task automatic run_frame(input bit sel, input int mode, input bit gapped,
                            input int stop_after);
      int w, h, n;
      logic signed [DW-1:0] d1, d2, l1, l2;
      exp_t e;
      w  = sel ? 5 : 4;
      h  = sel ? 5 : 4;
      n  = 0;
      l1 = '0;
      l2 = '0;
      for (int r = 0; r < h - 1; r++) begin
         for (int c = 0; c < w; c++) begin
            if (stop_after < 0 || n < stop_after) begin
               pixel(mode, r, c, w, h, d1, d2);
               e.cyc     = cyc + 1;
               e.has_out = (r % 2 == 0) && (c % 2 == 1);
               e.val     = smax(smax(l1, l2), smax(d1, d2));
               e.fd      = (r == h - 2) && (c == w - 1);
               if (e.has_out || e.fd) begin
                  if (sel) q_b.push_back(e);
                  else     q_a.push_back(e);
               end
               l1 = d1;
               l2 = d2;
               drive(sel, 1'b1, d1, d2);
               @(posedge clk); #1;
               n++;
               if (gapped) begin
                  drive(sel, 1'b0, $urandom(), $urandom());
                  @(posedge clk); #1;
               end
            end
         end
      end
      drive(sel, 1'b0, d1, d2);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      a_v = 1'b0; a_d1 = '0; a_d2 = '0;
      b_v = 1'b0; b_d1 = '0; b_d2 = '0;

      // Reset held with toggling inputs: all outputs stay at zero.
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, 1'($urandom()), $urandom(), $urandom());
         drive(1'b1, 1'($urandom()), $urandom(), $urandom());
         @(negedge clk);
         check("rst_a_d_out", a_out, '0);
         check("rst_a_valid_done", {30'b0, a_ov, a_fd}, '0);
         check("rst_b_d_out", b_out, '0);
         check("rst_b_valid_done", {30'b0, b_ov, b_fd}, '0);
      end
      drive(1'b0, 1'b0, '0, '0);
      drive(1'b1, 1'b0, '0, '0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic 4x4 window, then signed corners and a gapped repeat back to back.
      run_frame(1'b0, 0, 1'b0, -1);
      run_frame(1'b0, 1, 1'b0, -1);
      run_frame(1'b0, 0, 1'b1, -1);
      idle(4);
      check("a_hold_last", a_out, 32'd23);

      // Odd 5x5 geometry, two frames back to back (second one gapped).
      b_cnt = 0;
      run_frame(1'b1, 2, 1'b0, -1);
      run_frame(1'b1, 2, 1'b1, -1);
      idle(4);
      check("b_out_count", b_cnt, 32'd8);

      // Mid-frame reset after 6 beats, then a clean full frame.
      run_frame(1'b0, 0, 1'b0, 6);
      idle(2);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_d_out", a_out, '0);
      check("midrst_valid", {31'b0, a_ov}, '0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_frame(1'b0, 0, 1'b0, -1);
      idle(4);

      check("a_drain", q_a.size(), '0);
      check("b_drain", q_b.size(), '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
